audio_mem_fetch: RTL

Audio sample-memory fetch controller sitting directly upstream of `audio_mixer`. It generates the periodic audio DMA start pulse and services the mixer's single-word fetch requests. Each request goes to either the VRAM or TILE memory arbiter through a req/grant handshake, and the read word is returned to the mixer with a one-cycle ack. It guarantees that every accepted mixer fetch is answered by exactly one ack, even on arbiter starvation or audio disable, so the mixer can never hang in its read-wait state.

---
 rtl/audio_mem_fetch_if.sv | 26 ++
 rtl/audio_mem_fetch.sv | 131 +++++++++++++
 2 files changed

// File: rtl/audio_mem_fetch_if.sv
// Mixer fetch handshake plus VRAM/TILE arbiter request bus for audio_mem_fetch.
// slave is the fetch controller; master is the mixer/arbiter side driving it.
interface audio_mem_fetch_if;
    logic        fetch_i;
    logic        tile_i;
    logic [15:0] addr_i;
    logic        ack_o;
    logic [15:0] word_o;
    logic        vram_req_o;
    logic        tile_req_o;
    logic        vram_grant_i;
    logic        tile_grant_i;
    logic [15:0] mem_addr_o;
    logic [15:0] vram_data_i;
    logic [15:0] tile_data_i;

    modport slave (
        input  fetch_i, tile_i, addr_i, vram_grant_i, tile_grant_i, vram_data_i, tile_data_i,
        output ack_o, word_o, vram_req_o, tile_req_o, mem_addr_o
    );

    modport master (
        output fetch_i, tile_i, addr_i, vram_grant_i, tile_grant_i, vram_data_i, tile_data_i,
        input  ack_o, word_o, vram_req_o, tile_req_o, mem_addr_o
    );
endinterface

// File: rtl/audio_mem_fetch.sv
// Audio sample-memory fetch controller: periodic DMA start pulse and single-word
// mixer fetches through a VRAM/TILE req/grant handshake, always answered by one ack.
module audio_mem_fetch #(
    parameter int DMA_INTERVAL = 400,
    parameter int RD_LAT       = 1,
    parameter int TIMEOUT      = 1023
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              audio_enable_i,
    output logic              dma_start_o,
    audio_mem_fetch_if.slave  bus,
    output logic              busy_o,
    output logic              err_timeout_o,
    output logic              err_overrun_o
);
    localparam logic [15:0] INTERVAL_RELOAD = 16'(DMA_INTERVAL - 1);
    localparam logic [15:0] TIMEOUT_LAST    = 16'(TIMEOUT - 1);
    localparam logic [1:0]  LAT_LOAD        = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ACK} state_t;

    state_t      state_reg;
    logic [15:0] int_cnt_reg;
    logic        dma_start_reg;
    logic        tile_sel_reg;
    logic [15:0] addr_reg;
    logic [15:0] to_cnt_reg;
    logic [1:0]  lat_cnt_reg;
    logic        vram_req_reg;
    logic        tile_req_reg;
    logic        ack_reg;
    logic [15:0] word_reg;
    logic        err_timeout_reg;
    logic        err_overrun_reg;
    logic        grant_sel;

    assign grant_sel = tile_sel_reg ? bus.tile_grant_i : bus.vram_grant_i;

    // DMA cadence runs independently of the fetch FSM; disable parks it at reload.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            int_cnt_reg   <= INTERVAL_RELOAD;
            dma_start_reg <= 1'b0;
        end else if (!audio_enable_i) begin
            int_cnt_reg   <= INTERVAL_RELOAD;
            dma_start_reg <= 1'b0;
        end else if (int_cnt_reg == 16'd0) begin
            int_cnt_reg   <= INTERVAL_RELOAD;
            dma_start_reg <= 1'b1;
        end else begin
            int_cnt_reg   <= int_cnt_reg - 16'd1;
            dma_start_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg       <= IDLE;
            tile_sel_reg    <= 1'b0;
            addr_reg        <= 16'd0;
            to_cnt_reg      <= 16'd0;
            lat_cnt_reg     <= 2'd0;
            vram_req_reg    <= 1'b0;
            tile_req_reg    <= 1'b0;
            ack_reg         <= 1'b0;
            word_reg        <= 16'd0;
            err_timeout_reg <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            ack_reg         <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_overrun_reg <= bus.fetch_i && (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    if (bus.fetch_i) begin
                        tile_sel_reg <= bus.tile_i;
                        addr_reg     <= bus.addr_i;
                        to_cnt_reg   <= 16'd0;
                        vram_req_reg <= ~bus.tile_i;
                        tile_req_reg <= bus.tile_i;
                        state_reg    <= REQ;
                    end
                end
                REQ: begin
                    // Grant wins over disable/timeout: once granted the read is committed.
                    if (grant_sel) begin
                        vram_req_reg <= 1'b0;
                        tile_req_reg <= 1'b0;
                        lat_cnt_reg  <= LAT_LOAD;
                        state_reg    <= WAIT;
                    end else if (!audio_enable_i || (to_cnt_reg == TIMEOUT_LAST)) begin
                        vram_req_reg    <= 1'b0;
                        tile_req_reg    <= 1'b0;
                        word_reg        <= 16'd0;
                        ack_reg         <= 1'b1;
                        err_timeout_reg <= audio_enable_i;
                        state_reg       <= ACK;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 16'd1;
                    end
                end
                WAIT: begin
                    if (lat_cnt_reg == 2'd0) begin
                        word_reg  <= tile_sel_reg ? bus.tile_data_i : bus.vram_data_i;
                        ack_reg   <= 1'b1;
                        state_reg <= ACK;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 2'd1;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign dma_start_o    = dma_start_reg;
    assign busy_o         = (state_reg != IDLE);
    assign err_timeout_o  = err_timeout_reg;
    assign err_overrun_o  = err_overrun_reg;
    assign bus.ack_o      = ack_reg;
    assign bus.word_o     = word_reg;
    assign bus.vram_req_o = vram_req_reg;
    assign bus.tile_req_o = tile_req_reg;
    assign bus.mem_addr_o = addr_reg;
endmodule
